scan_frame_ctrl: RTL and testbench
==================================

SCAN_FRAME_CTRL -- requirements
Module: scan_frame_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 5, frame counter width.
REQ-002 SHALL have parameter CNT_LOAD, default 24, counter value loaded while cleared.
REQ-003 SHALL have parameter CNT_WRAP, default 25, counter value that toggles lclk.
REQ-004 SHALL have parameter DATA_W, default 2, test_in/test_out width.
REQ-005 SHALL have parameter CONF_DEPTH, default 2, consecutive matches that raise conflict (>=1).
REQ-006 SHALL have ports: clock in 1, rising-edge clock; reset in 1, asynchronous active-low reset (one clock; reset asynchronous, active-low).
REQ-007 SHALL have ports: s in 1 session enable; dv in 1 data valid; l_in in 1 lock input; test_in in DATA_W compare data.
REQ-008 SHALL have ports: scan_en in 1; scan_in in 1; scan_out out 1.
REQ-009 SHALL have ports: fz_L out 1 freeze; lclk out 1 frame clock; read_a out CNT_W counter; test_out out DATA_W; conflict out 1; state out 3.
REQ-010 SHALL have port signature out 16 (see Configuration).

Function
REQ-011 States: IDLE, WE, LZ, WR, SS, SD, STZ; unused codes SHALL go to IDLE.
REQ-012 IDLE: s=1,dv=0 -> WE, else IDLE. WE: s=0 -> IDLE; dv=0 -> WE; dv=1 -> LZ.
REQ-013 LZ: s=0 -> IDLE; l_in=0 -> SS; else WR. WR: s=0 -> IDLE; l_in=1 -> WR; else SS.
REQ-014 SS: s=0 or conflict -> IDLE, else SD. SD: s=0 or conflict -> IDLE; read_a==0 (full width) -> STZ; else SD.
REQ-015 STZ: s=0 or conflict -> IDLE; read_a==CNT_WRAP -> SS; else STZ.
REQ-016 clear = state in {IDLE,WE,LZ,WR}; clear: read_a <= CNT_LOAD, lclk <= 0; else read_a decrements mod 2^CNT_W.
REQ-017 Not clear and read_a==CNT_WRAP: lclk toggles; otherwise lclk holds.
REQ-018 fz_L SHALL be 1 only in SD (combinational from state).
REQ-019 test_out <= test_in + 2 in LZ/WR, else test_out + 1; mod 2^DATA_W.
REQ-020 match = (test_out == test_in); CONF_DEPTH-bit history shifts match in each functional cycle; conflict = AND of all history bits.
REQ-021 scan_en=1 SHALL override function: chain scan_in -> state[0..2] -> read_a[0..CNT_W-1] -> test_out[DATA_W-1..0] -> hist[0..CONF_DEPTH-1]; scan_out = hist[CONF_DEPTH-1]; lclk holds.
REQ-022 Chain length SHALL be 3+CNT_W+DATA_W+CONF_DEPTH (12 at defaults).

Reset
REQ-023 reset=0 SHALL immediately force state=IDLE, read_a=0, lclk=0, test_out=0, history=0, signature=0, independent of clock and scan_en.
REQ-024 Hence after reset: fz_L=0, conflict=0, scan_out=0; first post-reset cycle starts in IDLE.

Configuration
REQ-025 Macro SCAN_FRAME_CTRL_MISR_EN defined: 16-bit MISR, polynomial x^16+x^12+x^5+1, XORs {state,read_a,test_out} (zero-extended to 16) each functional cycle; holds during scan_en; not in scan chain.
REQ-026 Macro undefined: signature SHALL be constant 0 and no MISR flops exist.

Structure
REQ-027 Package scan_frame_pkg SHALL hold state encodings (IDLE=0, LZ=1, WR=2, SS=3, SD=4, STZ=5, WE=6) and the MISR polynomial constant.
REQ-028 Sub-module scan_frame_misr SHALL implement the MISR, instantiated only under the macro.

Verification
REQ-029 Reset: drop reset mid-SD with clock stopped -> all outputs 0, state=IDLE at once.
REQ-030 Sequence: s=1,dv=0 one cycle, dv=1, l_in=0, test_in held mismatching -> IDLE,WE,LZ,SS,SD; read_a=24 in SS, SD exits to STZ after read_a reaches 0, STZ returns to SS at read_a=25 with lclk toggled.
REQ-031 Conflict: in SS/SD drive test_in equal to test_out two consecutive cycles (CONF_DEPTH=2) -> conflict=1, next state IDLE; with CONF_DEPTH=3, two matches -> no exit.
REQ-032 Scan: scan_en=1, shift 12-bit 0xA5C, then 12 more cycles -> scan_out returns 0xA5C bit-serially; functional state unchanged meanwhile.
REQ-033 Wrap: CNT_W=4, CNT_LOAD=3, CNT_WRAP=14 -> read_a 0 -> 15 -> 14 in STZ, then SS.
REQ-034 With SCAN_FRAME_CTRL_MISR_EN: identical stimulus twice -> identical nonzero signature; without it signature=0.

Source files
------------

// File: rtl/scan_frame_pkg.sv
// rtl/scan_frame_pkg.sv - state encodings and MISR polynomial for scan_frame_ctrl
package scan_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LZ   = 3'd1,
        WR   = 3'd2,
        SS   = 3'd3,
        SD   = 3'd4,
        STZ  = 3'd5,
        WE   = 3'd6
    } state_t;

    localparam int          MISR_W    = 16;
    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                    input logic [MISR_W-1:0] data);
        logic [MISR_W-1:0] fb;
        fb = sig[MISR_W-1] ? MISR_POLY : '0;
        return {sig[MISR_W-2:0], 1'b0} ^ fb ^ data;
    endfunction

endpackage

// File: rtl/scan_frame_misr.sv
// rtl/scan_frame_misr.sv - 16-bit multiple-input signature register
module scan_frame_misr
    import scan_frame_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [MISR_W-1:0] data,
    output logic [MISR_W-1:0] signature
);

    logic [MISR_W-1:0] sig_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= misr_step(sig_q, data);
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/scan_frame_ctrl.sv
// rtl/scan_frame_ctrl.sv - frame FSM with counter, conflict detect and full scan chain
// Optional signature MISR enabled by SCAN_FRAME_CTRL_MISR_EN.
module scan_frame_ctrl
    import scan_frame_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int CNT_LOAD   = 24,
    parameter int CNT_WRAP   = 25,
    parameter int DATA_W     = 2,
    parameter int CONF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s,
    input  logic              dv,
    input  logic              l_in,
    input  logic [DATA_W-1:0] test_in,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic              fz_L,
    output logic              lclk,
    output logic [CNT_W-1:0]  read_a,
    output logic [DATA_W-1:0] test_out,
    output logic              conflict,
    output logic [2:0]        state,
    output logic [15:0]       signature
);

    localparam int CHAIN_W = 3 + CNT_W + DATA_W + CONF_DEPTH;
    localparam int CNT_OFS = 3;
    localparam int TST_OFS = 3 + CNT_W;
    localparam int HST_OFS = 3 + CNT_W + DATA_W;

    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(CNT_LOAD);
    localparam logic [CNT_W-1:0] WRAP_V = CNT_W'(CNT_WRAP);

    state_t                cur_st;
    state_t                nxt_st;
    state_t                fn_st;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      cnt_fn;
    logic                  lclk_q;
    logic                  lclk_d;
    logic                  lclk_fn;
    logic [DATA_W-1:0]     tout_q;
    logic [DATA_W-1:0]     tout_d;
    logic [DATA_W-1:0]     tout_fn;
    logic [CONF_DEPTH-1:0] hist_q;
    logic [CONF_DEPTH-1:0] hist_d;
    logic [CONF_DEPTH-1:0] hist_fn;
    logic                  clear;
    logic                  match;
    logic [CHAIN_W-1:0]    chain;
    logic [CHAIN_W-1:0]    chain_sh;
    logic [2:0]            sh_st;
    logic [CNT_W-1:0]      sh_cnt;
    logic [DATA_W-1:0]     sh_tout;
    logic [CONF_DEPTH-1:0] sh_hist;

    assign state    = cur_st;
    assign read_a   = cnt_q;
    assign lclk     = lclk_q;
    assign test_out = tout_q;
    assign conflict = &hist_q;
    assign fz_L     = (cur_st == SD);
    assign clear    = (cur_st == IDLE) || (cur_st == WE) || (cur_st == LZ) || (cur_st == WR);
    assign match    = (tout_q == test_in);
    assign scan_out = chain[CHAIN_W-1];

    always_comb begin
        fn_st = IDLE;
        case (cur_st)
            IDLE: fn_st = (s && !dv) ? WE : IDLE;
            WE: begin
                if (!s)      fn_st = IDLE;
                else if (dv) fn_st = LZ;
                else         fn_st = WE;
            end
            LZ: begin
                if (!s)        fn_st = IDLE;
                else if (l_in) fn_st = WR;
                else           fn_st = SS;
            end
            WR: begin
                if (!s)        fn_st = IDLE;
                else if (l_in) fn_st = WR;
                else           fn_st = SS;
            end
            SS: fn_st = (!s || conflict) ? IDLE : SD;
            SD: begin
                if (!s || conflict)  fn_st = IDLE;
                else if (cnt_q == '0) fn_st = STZ;
                else                 fn_st = SD;
            end
            STZ: begin
                if (!s || conflict)      fn_st = IDLE;
                else if (cnt_q == WRAP_V) fn_st = SS;
                else                     fn_st = STZ;
            end
            default: fn_st = IDLE;
        endcase
    end

    always_comb begin
        cnt_fn  = clear ? LOAD_V : cnt_q - CNT_W'(1);
        lclk_fn = clear ? 1'b0 : ((cnt_q == WRAP_V) ? ~lclk_q : lclk_q);
        tout_fn = ((cur_st == LZ) || (cur_st == WR)) ? test_in + DATA_W'(2)
                                                      : tout_q + DATA_W'(1);
        hist_fn = (hist_q << 1) | CONF_DEPTH'(match);
    end

    // Chain order: state[0..2], read_a[0..], test_out[MSB..0], hist[0..]
    always_comb begin
        chain = '0;
        for (int i = 0; i < 3; i++)          chain[i]                  = state[i];
        for (int i = 0; i < CNT_W; i++)      chain[CNT_OFS + i]        = cnt_q[i];
        for (int j = 0; j < DATA_W; j++)     chain[TST_OFS + j]        = tout_q[DATA_W-1-j];
        for (int k = 0; k < CONF_DEPTH; k++) chain[HST_OFS + k]        = hist_q[k];
        chain_sh = {chain[CHAIN_W-2:0], scan_in};

        sh_st   = '0;
        sh_cnt  = '0;
        sh_tout = '0;
        sh_hist = '0;
        for (int i = 0; i < 3; i++)          sh_st[i]            = chain_sh[i];
        for (int i = 0; i < CNT_W; i++)      sh_cnt[i]           = chain_sh[CNT_OFS + i];
        for (int j = 0; j < DATA_W; j++)     sh_tout[DATA_W-1-j] = chain_sh[TST_OFS + j];
        for (int k = 0; k < CONF_DEPTH; k++) sh_hist[k]          = chain_sh[HST_OFS + k];
    end

    always_comb begin
        nxt_st = fn_st;
        cnt_d  = cnt_fn;
        lclk_d = lclk_fn;
        tout_d = tout_fn;
        hist_d = hist_fn;
        if (scan_en) begin
            nxt_st = state_t'(sh_st);
            cnt_d  = sh_cnt;
            lclk_d = lclk_q;
            tout_d = sh_tout;
            hist_d = sh_hist;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_st <= IDLE;
            cnt_q  <= '0;
            lclk_q <= 1'b0;
            tout_q <= '0;
            hist_q <= '0;
        end else begin
            cur_st <= nxt_st;
            cnt_q  <= cnt_d;
            lclk_q <= lclk_d;
            tout_q <= tout_d;
            hist_q <= hist_d;
        end
    end

`ifdef SCAN_FRAME_CTRL_MISR_EN
    logic [3+CNT_W+DATA_W-1:0] misr_cap;
    logic [MISR_W-1:0]         misr_data;

    assign misr_cap  = {state, cnt_q, tout_q};
    assign misr_data = MISR_W'(misr_cap);

    scan_frame_misr u_misr (
        .clock     (clock),
        .reset     (reset),
        .en        (~scan_en),
        .data      (misr_data),
        .signature (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_frame_ctrl.sv
// tb/tb_scan_frame_ctrl.sv - scoreboard bench for scan_frame_ctrl (default and wrap/depth-3 instances)
module tb_scan_frame_ctrl;

    logic       clock   = 1'b0;
    logic       clk_en  = 1'b1;
    logic       reset   = 1'b0;
    logic       s       = 1'b0;
    logic       dv      = 1'b0;
    logic       l_in    = 1'b0;
    logic       scan_en = 1'b0;
    logic       scan_in = 1'b0;
    logic [1:0] test_in = 2'd0;

    logic        a_scan_out, a_fz, a_lclk, a_conf;
    logic [4:0]  a_read_a;
    logic [1:0]  a_tout;
    logic [2:0]  a_state;
    logic [15:0] a_sig;

    logic        b_scan_out, b_fz, b_lclk, b_conf;
    logic [3:0]  b_read_a;
    logic [1:0]  b_tout;
    logic [2:0]  b_state;
    logic [15:0] b_sig;

    scan_frame_ctrl dut_a (
        .clock(clock), .reset(reset), .s(s), .dv(dv), .l_in(l_in), .test_in(test_in),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(a_scan_out), .fz_L(a_fz),
        .lclk(a_lclk), .read_a(a_read_a), .test_out(a_tout), .conflict(a_conf),
        .state(a_state), .signature(a_sig)
    );

    scan_frame_ctrl #(.CNT_W(4), .CNT_LOAD(3), .CNT_WRAP(14), .DATA_W(2), .CONF_DEPTH(3)) dut_b (
        .clock(clock), .reset(reset), .s(s), .dv(dv), .l_in(l_in), .test_in(test_in),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(b_scan_out), .fz_L(b_fz),
        .lclk(b_lclk), .read_a(b_read_a), .test_out(b_tout), .conflict(b_conf),
        .state(b_state), .signature(b_sig)
    );

    always #5 if (clk_en) clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] ra;
        logic       lk;
        logic [1:0] to;
        logic       cf;
        logic       fz;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] m_st;
    logic [4:0] m_ra;
    logic       m_lk;
    logic [1:0] m_to;
    logic [1:0] m_h;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         b_st[7] = '{3, 4, 4, 4, 5, 5, 3};
    int         b_ra[7] = '{3, 2, 1, 0, 15, 14, 13};
    logic [15:0] sig1, sig2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 3'd0; m_ra = 5'd0; m_lk = 1'b0; m_to = 2'd0; m_h = 2'd0;
        sb_q.delete();
    endtask

    // Advance the reference model by one clock with the inputs now applied
    task automatic push_step();
        logic [2:0] ns;
        logic [4:0] nra;
        logic       cf;
        exp_t       e;
        cf = &m_h;
        case (m_st)
            3'd0: ns = (s && !dv) ? 3'd6 : 3'd0;
            3'd6: ns = !s ? 3'd0 : (dv ? 3'd1 : 3'd6);
            3'd1, 3'd2: ns = !s ? 3'd0 : (l_in ? 3'd2 : 3'd3);
            3'd3: ns = (!s || cf) ? 3'd0 : 3'd4;
            3'd4: ns = (!s || cf) ? 3'd0 : ((m_ra == 5'd0) ? 3'd5 : 3'd4);
            3'd5: ns = (!s || cf) ? 3'd0 : ((m_ra == 5'd25) ? 3'd3 : 3'd5);
            default: ns = 3'd0;
        endcase
        if (m_st == 3'd0 || m_st == 3'd6 || m_st == 3'd1 || m_st == 3'd2) begin
            nra  = 5'd24;
            m_lk = 1'b0;
        end else begin
            nra = m_ra - 5'd1;
            if (m_ra == 5'd25) m_lk = ~m_lk;
        end
        m_h  = {m_h[0], (m_to == test_in)};
        m_to = (m_st == 3'd1 || m_st == 3'd2) ? test_in + 2'd2 : m_to + 2'd1;
        m_ra = nra;
        m_st = ns;
        e = '{st: m_st, ra: m_ra, lk: m_lk, to: m_to, cf: &m_h, fz: (m_st == 3'd4)};
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        push_step();
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk("state",    a_state,  e.st);
        chk("read_a",   a_read_a, e.ra);
        chk("lclk",     a_lclk,   e.lk);
        chk("test_out", a_tout,   e.to);
        chk("conflict", a_conf,   e.cf);
        chk("fz_L",     a_fz,     e.fz);
    endtask

    task automatic do_reset();
        reset = 1'b0; s = 1'b0; dv = 1'b0; l_in = 1'b0;
        scan_en = 1'b0; scan_in = 1'b0; test_in = 2'd0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic scan_test();
        logic [11:0] pat = 12'hA5C;
        s = 1'b1; dv = 1'b0; scan_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            scan_in = pat[11-i];
            chk("scan_fill_a", a_scan_out, 1'b0);
            chk("scan_fill_b", b_scan_out, 1'b0);
            @(posedge clock);
            #1;
        end
        chk("scan_state_a",  a_state,  3'd4);
        chk("scan_read_a_a", a_read_a, 5'd11);
        chk("scan_tout_a",   a_tout,   2'd1);
        chk("scan_lclk_a",   a_lclk,   1'b0);
        chk("scan_fz_a",     a_fz,     1'b1);
        chk("scan_conf_a",   a_conf,   1'b0);
        chk("scan_state_b",  b_state,  3'd4);
        chk("scan_read_a_b", b_read_a, 4'd11);
        chk("scan_tout_b",   b_tout,   2'd0);
        scan_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("scan_out_a", a_scan_out, pat[11-i]);
            chk("scan_out_b", b_scan_out, pat[11-i]);
            @(posedge clock);
            #1;
        end
        scan_en = 1'b0; s = 1'b0;
        chk("scan_flush_state", a_state,  3'd0);
        chk("scan_flush_cnt",   a_read_a, 5'd0);
        model_reset();
    endtask

    task automatic run_seq(output logic [15:0] sig);
        do_reset();
        s = 1'b1; dv = 1'b0; step();
        dv = 1'b1; step();
        l_in = 1'b0; step();
        for (int i = 0; i < 40; i++) begin
            test_in = 2'(i ^ (i >> 2));
            step();
        end
        sig = a_sig;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_state",    a_state,    3'd0);
        chk("rst_read_a",   a_read_a,   5'd0);
        chk("rst_lclk",     a_lclk,     1'b0);
        chk("rst_tout",     a_tout,     2'd0);
        chk("rst_conf",     a_conf,     1'b0);
        chk("rst_fz",       a_fz,       1'b0);
        chk("rst_scan_out", a_scan_out, 1'b0);
        chk("rst_sig",      a_sig,      16'd0);
        chk("rst_state_b",  b_state,    3'd0);

        scan_test();

        // Frame sequence with test_in held constant
        s = 1'b1; dv = 1'b0; test_in = 2'd1; step();
        dv = 1'b1; step();
        l_in = 1'b0; step();
        chk("ss_load", a_read_a, 5'd24);
        for (int i = 0; i < 70; i++) begin
            if (i < 7) begin
                chk("wrap_state_b", b_state,  b_st[i]);
                chk("wrap_read_b",  b_read_a, b_ra[i]);
            end
            if (i == 6) chk("wrap_lclk_b", b_lclk, 1'b1);
            step();
        end

        // Two consecutive matches: depth-2 instance exits, depth-3 instance stays
        test_in = m_to + 2'd1; step();
        test_in = m_to; step();
        test_in = m_to; step();
        chk("conflict_a",   a_conf, 1'b1);
        chk("conflict_b",   b_conf, 1'b0);
        test_in = m_to + 2'd1; step();
        chk("conf_exit_a",  a_state, 3'd0);
        chk("no_exit_b",    (b_state == 3'd3 || b_state == 3'd4 || b_state == 3'd5), 1'b1);

        // Re-enter through WR, then reset asynchronously in SD with the clock stopped
        dv = 1'b0; test_in = 2'd0; l_in = 1'b1; step();
        dv = 1'b1; step();
        step();
        step();
        l_in = 1'b0;
        for (int i = 0; i < 6 && m_st != 3'd4; i++) step();
        chk("pre_reset_sd", a_state, 3'd4);
        clk_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_state",    a_state,    3'd0);
        chk("async_read_a",   a_read_a,   5'd0);
        chk("async_lclk",     a_lclk,     1'b0);
        chk("async_tout",     a_tout,     2'd0);
        chk("async_conf",     a_conf,     1'b0);
        chk("async_fz",       a_fz,       1'b0);
        chk("async_scan_out", a_scan_out, 1'b0);
        chk("async_state_b",  b_state,    3'd0);
        #1;
        reset = 1'b1;
        clk_en = 1'b1;
        model_reset();

        run_seq(sig1);
`ifdef SCAN_FRAME_CTRL_MISR_EN
        run_seq(sig2);
        chk("sig_repeat",  sig2, sig1);
        chk("sig_nonzero", (sig1 != 16'd0), 1'b1);
`else
        sig2 = b_sig;
        chk("sig_zero_a", sig1, 16'd0);
        chk("sig_zero_b", sig2, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
